mem_port_arbiter: RTL

- Shares one single-port unified instruction/data memory between the fetch stage (I-port) and the memory stage (D-port) of the 5-stage pipelined core.
- Serialises requests, drives a registered req/ready handshake to the memory, and returns read data with one-cycle valid pulses.
- Produces stall qualifiers that the hazard unit ORs into the fetch and memory stall terms.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/mem_arb_perf_cnt.sv | 32 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: state encoding,
// port identifiers and default bus widths.
`timescale 1ns/1ps
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating wait-cycle counters for the fetch and memory ports.
// Only built when MEM_ARB_PERF_CNT_EN is defined.
`timescale 1ns/1ps
`ifdef MEM_ARB_PERF_CNT_EN
module mem_arb_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stallF,
  input  logic        i_stallM,
  output logic [31:0] o_perfI,
  output logic [31:0] o_perfD
);

  logic [31:0] r_perfI;
  logic [31:0] r_perfD;

  // Each counter sticks at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfI <= '0;
      r_perfD <= '0;
    end else begin
      if (i_stallF && (r_perfI != '1)) r_perfI <= r_perfI + 32'd1;
      if (i_stallM && (r_perfD != '1)) r_perfD <= r_perfD + 32'd1;
    end
  end

  assign o_perfI = r_perfI;
  assign o_perfD = r_perfD;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and
// memory-stage (D) requesters. Optional counters: MEM_ARB_PERF_CNT_EN.
`timescale 1ns/1ps
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       perf_i_wait,
  output logic [31:0]       perf_d_wait
);

  arb_state_e        r_state;
  arb_state_e        w_nextState;
  logic              r_lastGnt;
  logic              r_memReq;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic              r_iValid;
  logic              r_dValid;

  logic              w_iElig;
  logic              w_dElig;
  logic              w_grantI;
  logic              w_grantD;
  logic              w_issue;
  logic              w_doneI;
  logic              w_doneD;

  // A port whose valid is pulsing this cycle is finished and must not be re-granted yet.
  assign w_iElig  = i_req & ~r_iValid;
  assign w_dElig  = d_req & ~r_dValid;
  assign w_grantD = w_dElig & (~w_iElig | (r_lastGnt == PORT_I));
  assign w_grantI = w_iElig & ~w_grantD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grantD)      w_nextState = BUSY_D;
        else if (w_grantI) w_nextState = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_doneI = 1'b0;
    w_doneD = 1'b0;
    unique case (r_state)
      IDLE:    w_issue = w_grantI | w_grantD;
      BUSY_I:  w_doneI = mem_ready;
      BUSY_D:  w_doneD = mem_ready;
      default: w_issue = 1'b0;
    endcase
  end

  // Memory-side signals stay frozen from issue until the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastGnt  <= PORT_I;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_iRdata   <= '0;
      r_dRdata   <= '0;
      r_iValid   <= 1'b0;
      r_dValid   <= 1'b0;
    end else begin
      r_iValid <= w_doneI;
      r_dValid <= w_doneD;
      if (w_issue) begin
        r_memReq <= 1'b1;
        if (w_grantD) begin
          r_memAddr  <= d_addr;
          r_memWe    <= d_we;
          r_memWdata <= d_wdata;
          r_lastGnt  <= PORT_D;
        end else begin
          r_memAddr  <= i_addr;
          r_memWe    <= 1'b0;
          r_lastGnt  <= PORT_I;
        end
      end else if (w_doneI || w_doneD) begin
        r_memReq <= 1'b0;
      end
      if (w_doneI) r_iRdata <= mem_rdata;
      if (w_doneD && !r_memWe) r_dRdata <= mem_rdata;
    end
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign i_rdata   = r_iRdata;
  assign d_rdata   = r_dRdata;
  assign i_valid   = r_iValid;
  assign d_valid   = r_dValid;
  assign stall_f   = i_req & ~r_iValid;
  assign stall_m   = d_req & ~r_dValid;

`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_cnt u_perfCnt (
    .clk      (clk),
    .rst      (rst),
    .i_stallF (stall_f),
    .i_stallM (stall_m),
    .o_perfI  (perf_i_wait),
    .o_perfD  (perf_d_wait)
  );
`else
  assign perf_i_wait = '0;
  assign perf_d_wait = '0;
`endif

endmodule
